// File: rtl/uart_tx_fifo.sv
// Byte FIFO that feeds a UART transmitter: pushes are queued in DEPTH x 8 storage
// and drained one strobe at a time, handshaking on the transmitter's busy flag.
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [7:0]               i_data,
  input  logic                     i_wr,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic [7:0]               o_char,
  output logic                     o_write,
  input  logic                     i_tx_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    char_q, char_d;
  logic          write_q, write_d;
  state_e        state_q, state_d;
  logic          push_s;
  logic          pop_s;

  // Next-state for the drain FSM, pointers, occupancy and status flags.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    char_d     = char_q;
    write_d    = 1'b0;
    pop_s      = 1'b0;
    // Full is judged on the registered count, so a pop cannot rescue a push.
    push_s     = i_wr & ~full_q;
    overflow_d = overflow_q | (i_wr & full_q);

    case (state_q)
      ST_IDLE: begin
        if (!empty_q && !i_tx_busy) begin
          pop_s   = 1'b1;
          write_d = 1'b1;
          char_d  = mem_q[rd_ptr_q];
          state_d = ST_ACK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (i_tx_busy) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ACK;
        end
      end
      ST_DONE: begin
        if (!i_tx_busy) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    count_d = count_q + CW'(push_s) - CW'(pop_s);
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == CW'(0));
  end

  // Control and status registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      char_q     <= 8'h00;
      write_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      char_q     <= char_d;
      write_q    <= write_d;
    end
  end

  // Storage is left unreset; writes are suppressed while reset is asserted.
  always_ff @(posedge i_clk) begin
    if (!i_rst && push_s) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  assign o_full     = full_q;
  assign o_empty    = empty_q;
  assign o_count    = count_q;
  assign o_overflow = overflow_q;
  assign o_char     = char_q;
  assign o_write    = write_q;

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO entry count (power of two, minimum 2).
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_data  input  8  byte to enqueue.
REQ-005 SHALL have port i_wr  input  1  push request; one byte per cycle while high.
REQ-006 SHALL have port o_full  output  1  registered; high when count == DEPTH.
REQ-007 SHALL have port o_empty  output  1  registered; high when count == 0.
REQ-008 SHALL have port o_count  output  log2(DEPTH)+1  registered occupancy.
REQ-009 SHALL have port o_overflow  output  1  sticky; set when a push is dropped.
REQ-010 SHALL have port o_char  output  8  byte to the transmitter (connects to uart_tx i_char).
REQ-011 SHALL have port o_write  output  1  one-cycle send strobe (connects to uart_tx i_write).
REQ-012 SHALL have port i_tx_busy  input  1  transmitter busy (connects to uart_tx o_busy).

Function
REQ-013 SHALL store bytes in DEPTH x 8 storage with log2(DEPTH)-bit read/write pointers that wrap modulo DEPTH.
REQ-014 SHALL accept a push when i_wr=1 and o_full=0: write i_data at wr_ptr, increment wr_ptr, increment count.
REQ-015 SHALL drop a push when i_wr=1 and o_full=1, leave storage/pointers unchanged, and set o_overflow=1 on the next edge.
REQ-016 SHALL evaluate full against the registered count; a push while full is dropped even if a pop occurs in the same cycle.
REQ-017 SHALL implement drain FSM states IDLE, ACK and DONE.
REQ-018 IDLE: if count>0 and i_tx_busy=0, SHALL on the edge register o_char=mem[rd_ptr], set o_write=1, increment rd_ptr, decrement count, and go to ACK; otherwise remain in IDLE with o_write=0.
REQ-019 ACK: SHALL drive o_write=0 on the next edge (strobe exactly one cycle wide), and go to DONE when i_tx_busy=1 is sampled.
REQ-020 DONE: SHALL remain until i_tx_busy=0 is sampled, then return to IDLE; no new strobe is issued in the same cycle.
REQ-021 SHALL hold o_char stable from the strobe until the next strobe.
REQ-022 On simultaneous push and pop with 0<count<DEPTH, SHALL leave count unchanged and advance both pointers.
REQ-023 On a push into an empty FIFO at edge N, with FSM in IDLE and i_tx_busy=0, SHALL assert o_write at edge N+1; there is no same-cycle bypass.
REQ-024 SHALL never issue o_write while the FIFO is empty; count SHALL never underflow or exceed DEPTH.
REQ-025 SHALL update o_full, o_empty and o_count on the same edge as the pointer change.

Reset
REQ-026 i_rst=1 SHALL, on the edge, clear pointers and count, set FSM to IDLE, and force o_write=0, o_overflow=0, o_empty=1, o_full=0, o_char=8'h00.
REQ-027 Storage contents SHALL NOT be reset; pushes with i_wr=1 during reset SHALL be ignored.
REQ-028 Reset mid-drain SHALL discard queued bytes; a byte already strobed completes in the transmitter, and IDLE SHALL wait for i_tx_busy=0 before issuing again.

Verification
REQ-029 Single byte: push 8'hA5 with i_tx_busy=0 -> o_write high for exactly 1 cycle one edge later, o_char=8'hA5, o_empty back to 1.
REQ-030 Order: push 8'h01,8'h02,8'h03 back-to-back with a busy model holding 4 cycles per byte -> three strobes carrying 01,02,03 in order, no strobe while i_tx_busy=1.
REQ-031 Full/overflow: hold i_tx_busy=1, push 17 bytes at DEPTH=16 -> o_full=1 and o_count=16 after the 16th push, 17th dropped, o_overflow=1 until reset.
REQ-032 Wrap: 40 pushes/pops interleaved with random busy at DEPTH=16 -> output sequence equals input sequence, o_count never >16.
REQ-033 Simultaneous: count=5, push on the same edge as a strobe -> o_count stays 5, both pointers advance.
REQ-034 Reset mid-drain: 6 bytes queued, i_rst pulsed after the 2nd strobe -> o_count=0, o_empty=1, o_write=0, o_overflow=0; no further strobes until a new push.
